seg_scan_driver: RTL

//  Time-multiplexed driver for the board's 8-digit seven-segment display.
//  - Generates its own refresh tick from the system clock.
//  - Steps a digit index across all digits.
//  - Decodes each 4-bit hex nibble to active-low segment and anode lines.
//  - Latches display data in a shadow register that updates only at frame boundaries, so a digit never shows a half-updated value.

---
 rtl/seg_pkg.sv | 18 +
 rtl/seg_hex_decode.sv | 14 +
 rtl/seg_scan_driver.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan driver.
//   SEG_BLANK : all segments off (active-low)
//   HEX2SEG   : nibble -> {g,f,e,d,c,b,a} active-low pattern
//   idx_width : bit width needed to hold values 0..n-1 (minimum 1)
package seg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] HEX2SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to seven-segment decoder.
// Ports:
//   nibble_i : 4-bit hex value
//   seg_o    : {g,f,e,d,c,b,a}, active-low
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    assign seg_o = HEX2SEG[nibble_i];

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed driver for a multi-digit seven-segment display.
// A prescaler generates a per-digit tick, an index scans the digits, and the
// display data is double-buffered so new data only takes effect at a frame wrap.
// Optional feature: define LEADING_ZERO_BLANK_EN to suppress leading zeros.
// Ports:
//   clk, reset  : system clock, asynchronous active-high reset
//   digits_i    : hex nibbles, digit 0 in bits [3:0]
//   dp_i        : decimal points, 1 = lit
//   load_i      : capture strobe for digits_i/dp_i
//   an_o        : anodes, active-low, at most one low
//   seg_o       : {g,f,e,d,c,b,a}, active-low
//   dp_o        : decimal point, active-low
//   digit_idx_o : digit currently scanned
//   frame_o     : one-cycle pulse after the index wraps to 0
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int unsigned CLK_HZ       = 100_000_000,
    parameter int unsigned REFRESH_HZ   = 1000,
    parameter int unsigned NUM_DIGITS   = 8,
    parameter int unsigned BLANK_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] digits_i,
    input  logic [NUM_DIGITS-1:0]   dp_i,
    input  logic                    load_i,
    output logic [NUM_DIGITS-1:0]   an_o,
    output logic [6:0]              seg_o,
    output logic                    dp_o,
    output logic [2:0]              digit_idx_o,
    output logic                    frame_o
);

    localparam int unsigned DIV   = CLK_HZ / REFRESH_HZ;
    localparam int unsigned CNT_W = idx_width(DIV);
    localparam int unsigned IDX_W = idx_width(NUM_DIGITS);

    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] act_dig_q, pend_dig_q;
    logic [NUM_DIGITS-1:0]   act_dp_q, pend_dp_q;
    logic                    pend_flag_q;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic [2:0]              idx_out_q;
    logic                    frame_q;

    logic       tick, wrap, blank, suppress;
    logic [3:0] cur_nib;
    logic       cur_dp;
    logic [6:0] hex_seg;

    assign tick = (cnt_q == CNT_W'(DIV - 1));
    assign wrap = tick && (idx_q == IDX_W'(NUM_DIGITS - 1));

    always_comb begin
        cnt_d = tick ? '0 : cnt_q + 1'b1;
        idx_d = idx_q;
        if (tick) idx_d = wrap ? '0 : idx_q + 1'b1;
    end

    assign cur_nib = act_dig_q[{idx_q, 2'b00} +: 4];
    assign cur_dp  = act_dp_q[idx_q];

    seg_hex_decode u_hex (
        .nibble_i (cur_nib),
        .seg_o    (hex_seg)
    );

`ifdef LEADING_ZERO_BLANK_EN
    // zero_run[i]: nibble i and every higher nibble are zero.
    logic [NUM_DIGITS-1:0] zero_run;
    always_comb begin
        zero_run = '0;
        zero_run[NUM_DIGITS-1] = (act_dig_q[4*NUM_DIGITS-1 -: 4] == 4'h0);
        for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
            zero_run[i] = (act_dig_q[i*4 +: 4] == 4'h0) && zero_run[i+1];
        end
    end
    assign suppress = zero_run[idx_q] && !cur_dp && (idx_q != '0);
`else
    assign suppress = 1'b0;
`endif

    // Anti-ghosting: all segments and anodes off for the first BLANK_CYCLES of a slot.
    assign blank = (cnt_q < CNT_W'(BLANK_CYCLES));

    always_comb begin
        an_d  = '1;
        seg_d = SEG_BLANK;
        dp_d  = 1'b1;
        if (!blank) begin
            an_d  = ~(NUM_DIGITS'(1) << idx_q);
            seg_d = suppress ? SEG_BLANK : hex_seg;
            dp_d  = ~cur_dp;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q       <= '0;
            idx_q       <= '0;
            act_dig_q   <= '0;
            act_dp_q    <= '0;
            pend_dig_q  <= '0;
            pend_dp_q   <= '0;
            pend_flag_q <= 1'b0;
            an_q        <= '1;
            seg_q       <= SEG_BLANK;
            dp_q        <= 1'b1;
            idx_out_q   <= '0;
            frame_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
            idx_out_q <= 3'(idx_q);
            frame_q   <= wrap;
            if (load_i) begin
                pend_dig_q <= digits_i;
                pend_dp_q  <= dp_i;
            end
            if (wrap) begin
                // A load coinciding with the wrap bypasses the pending buffer.
                if (load_i) begin
                    act_dig_q <= digits_i;
                    act_dp_q  <= dp_i;
                end else if (pend_flag_q) begin
                    act_dig_q <= pend_dig_q;
                    act_dp_q  <= pend_dp_q;
                end
                pend_flag_q <= 1'b0;
            end else if (load_i) begin
                pend_flag_q <= 1'b1;
            end
        end
    end

    assign an_o        = an_q;
    assign seg_o       = seg_q;
    assign dp_o        = dp_q;
    assign digit_idx_o = idx_out_q;
    assign frame_o     = frame_q;

endmodule
